key_expand_seq: RTL and testbench

- Sequential AES key-expansion engine for AES-128, AES-192 and AES-256, selected by parameter.
- Generates one 32-bit schedule word per clock, reusing a single 4-byte S-box bank.
- Assembles every four words into a 128-bit round key and streams the round keys out over a valid/ready handshake.
- Sits between the key register and the round datapath; replaces per-round combinational key logic.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_sbox.sv | 24 ++
 rtl/key_expand_seq_word_gen.sv | 23 ++
 rtl/key_expand_seq.sv | 84 ++++++++
 tb/tb_key_expand_seq.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule types, sizing helpers and byte/word primitives
package aes_pkg;
  typedef logic [31:0] word_t;
  typedef logic [127:0] rkey_t;
  typedef enum logic [1:0] {IDLE, EXPAND, FLUSH} state_t;
  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;
  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction
  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction
  function automatic int nw_of(input int key_bits);
    return 4 * (key_bits / 32 + 7);
  endfunction
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box, GF(2^8) inverse (x^254) followed by the affine map
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction
  logic [7:0] y, b;
  always_comb begin
    y = a;
    for (int k = 0; k < 6; k++) y = gmul(gmul(y, y), a);
    b = gmul(y, y);
    s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end
endmodule

// File: rtl/key_expand_seq_word_gen.sv
// key_word_gen: combinational next schedule word from w[i-1], w[i-NK], i%NK and Rcon
module key_word_gen
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  word_t      prev,
  input  word_t      old,
  input  logic [2:0] phase,
  input  logic [7:0] rcon,
  input  logic       use_key,
  output word_t      w
);
  word_t s_in, s_out, t;
  assign s_in = phase == 3'd0 ? rot_word(prev) : prev;
  for (genvar g = 0; g < 4; g++) begin : g_sb
    aes_sbox u_sbox (.a(s_in[8*g +: 8]), .s(s_out[8*g +: 8]));
  end
  always_comb begin
    t = phase == 3'd0 ? s_out ^ {rcon, 24'h0} : (NK == 8 && phase == 3'd4) ? s_out : prev;
    w = use_key ? old : old ^ t;
  end
endmodule

// File: rtl/key_expand_seq.sv
// key_expand_seq: one schedule word per clock, streaming 128-bit round keys over valid/ready
module key_expand_seq
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [127:0]        rk_out,
  output logic [3:0]          rk_index,
  output logic                done
);
  localparam int NK = nk_of(KEY_BITS);
  localparam int NW = nw_of(KEY_BITS);
  localparam logic [5:0] LAST = 6'(NW - 1);
  localparam logic [5:0] NK6 = 6'(NK);
  localparam logic [2:0] PLAST = 3'(NK - 1);
  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("key_expand_seq: KEY_BITS must be 128, 192 or 256");
  end
  state_t state, state_nx;
  logic [5:0] i;
  logic [2:0] phase;
  logic [1:0] slot;
  logic [7:0] rcon;
  logic [95:0] acc;
  word_t win [NK];
  word_t w;
  logic adv, hs;
  assign hs = rk_valid && rk_ready;
  assign adv = state == EXPAND && (!rk_valid || rk_ready);
  assign busy = state != IDLE;
  always_comb begin
    state_nx = (state == IDLE && start) ? EXPAND :
               (adv && i == LAST)       ? FLUSH  :
               (state == FLUSH && hs)   ? IDLE   : state;
  end
  // for i<NK the window rotates, emitting the key words and ending up holding them again
  key_word_gen #(.NK(NK)) u_gen (
    .prev(win[NK-1]), .old(win[0]), .phase(phase), .rcon(rcon), .use_key(i < NK6), .w(w)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      i <= '0;
      phase <= '0;
      slot <= '0;
      rcon <= '0;
      acc <= '0;
      rk_valid <= 1'b0;
      rk_out <= '0;
      rk_index <= '0;
      done <= 1'b0;
      for (int k = 0; k < NK; k++) win[k] <= '0;
    end else begin
      state <= state_nx;
      done <= state == FLUSH && hs;
      if (state == IDLE && start) begin
        for (int k = 0; k < NK; k++) win[k] <= key_in[KEY_BITS-1-32*k -: 32];
        i <= '0;
        phase <= '0;
        slot <= '0;
        rcon <= 8'h01;
      end else if (adv) begin
        for (int k = 0; k < NK - 1; k++) win[k] <= win[k+1];
        win[NK-1] <= w;
        i <= i + 6'd1;
        phase <= phase == PLAST ? 3'd0 : phase + 3'd1;
        slot <= slot + 2'd1;
        acc <= {acc[63:0], w};
        if (phase == 3'd0 && i >= NK6) rcon <= xtime(rcon);
      end
      if (adv && slot == 2'd3) begin
        rk_out <= {acc, w};
        rk_index <= i[5:2];
        rk_valid <= 1'b1;
      end else if (hs) rk_valid <= 1'b0;
    end
endmodule

// File: tb/tb_key_expand_seq.sv
// tb_key_expand_seq: AES-128/192/256 key schedules checked against a FIPS-197 reference model
module tb_key_expand_seq;
  localparam logic [0:2047] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st [3] = '{1'b0, 1'b0, 1'b0};
  logic rdy [3] = '{1'b1, 1'b1, 1'b1};
  logic bz [3], rv [3], dn [3];
  logic [127:0] ro [3];
  logic [3:0] ri [3];
  logic [127:0] k128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [191:0] k192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  logic [255:0] k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  logic [31:0] ws [60];
  logic [127:0] got [15];
  int n_cmp = 0, n_bad = 0;
  int nhs, dcyc, dcnt;
  always #5 clk = ~clk;
  key_expand_seq #(.KEY_BITS(128)) u128 (.clk(clk), .rst_n(rst_n), .start(st[0]), .key_in(k128),
    .busy(bz[0]), .rk_valid(rv[0]), .rk_ready(rdy[0]), .rk_out(ro[0]), .rk_index(ri[0]), .done(dn[0]));
  key_expand_seq #(.KEY_BITS(192)) u192 (.clk(clk), .rst_n(rst_n), .start(st[1]), .key_in(k192),
    .busy(bz[1]), .rk_valid(rv[1]), .rk_ready(rdy[1]), .rk_out(ro[1]), .rk_index(ri[1]), .done(dn[1]));
  key_expand_seq #(.KEY_BITS(256)) u256 (.clk(clk), .rst_n(rst_n), .start(st[2]), .key_in(k256),
    .busy(bz[2]), .rk_valid(rv[2]), .rk_ready(rdy[2]), .rk_out(ro[2]), .rk_index(ri[2]), .done(dn[2]));
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] sub(input logic [31:0] x);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = SB[int'(x[8*b +: 8]) * 8 +: 8];
    return r;
  endfunction
  // textbook FIPS-197 expansion with key word 0 at bits 255:224
  task automatic build(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) ws[i] = key[255-32*i -: 32];
      else begin
        t = ws[i-1];
        if (i % nk == 0) begin
          t = sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = rc[7] ? {rc[6:0], 1'b0} ^ 8'h1b : {rc[6:0], 1'b0};
        end else if (nk == 8 && i % nk == 4) t = sub(t);
        ws[i] = ws[i-nk] ^ t;
      end
    end
  endtask
  function automatic logic [127:0] rk_model(input int j);
    return {ws[4*j], ws[4*j+1], ws[4*j+2], ws[4*j+3]};
  endfunction
  task automatic run(input int k, input bit rnd, input int abort_at,
                     output int nh, output int dc, output int dcount);
    logic [131:0] held;
    bit stalled;
    nh = 0; dc = -1; dcount = 0; stalled = 0; held = '0;
    @(negedge clk);
    st[k] = 1'b1;
    rdy[k] = 1'b1;
    @(posedge clk);
    #1 st[k] = 1'b0;
    chk("busy_after_start", 256'(bz[k]), 256'd1);
    for (int c = 1; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (stalled) chk("stall_hold", 256'({rv[k], ri[k], ro[k]}), 256'({1'b1, held}));
      if (dn[k]) begin
        dcount++;
        if (dc < 0) dc = c;
        chk("busy_at_done", 256'(bz[k]), 256'd0);
      end
      if (dc >= 0 && c >= dc + 3) break;
      rdy[k] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      st[k] = rnd && bz[k] && ($urandom_range(0, 3) == 0);
      stalled = rv[k] && !rdy[k];
      held = {ri[k], ro[k]};
      if (rv[k] && rdy[k]) begin
        chk("rk_index", 256'(ri[k]), 256'(nh));
        chk("rk_value", 256'(ro[k]), 256'(rk_model(nh)));
        if (!rnd) chk("rk_timing", 256'(c), 256'(4 * nh + 4));
        if (nh < 15) got[nh] = ro[k];
        nh++;
        if (nh == abort_at) break;
      end
    end
    if (abort_at < 0) chk("done_seen", 256'(dc >= 0), 256'd1);
    st[k] = 1'b0;
    rdy[k] = 1'b1;
  endtask
  initial begin
    #1;
    for (int k = 0; k < 3; k++) chk("reset_state", 256'({bz[k], rv[k], dn[k], ri[k], ro[k]}), 256'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    build(4, {k128, 128'h0});
    run(0, 0, -1, nhs, dcyc, dcnt);
    chk("aes128_handshakes", 256'(nhs), 256'd11);
    chk("aes128_done_cycle", 256'(dcyc), 256'd45);
    chk("aes128_done_once", 256'(dcnt), 256'd1);
    chk("aes128_rk1", 256'(got[1]), 256'(128'ha0fafe1788542cb123a339392a6c7605));
    chk("aes128_rk10", 256'(got[10]), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    run(0, 1, -1, nhs, dcyc, dcnt);
    chk("aes128_rnd_handshakes", 256'(nhs), 256'd11);
    chk("aes128_rnd_done_once", 256'(dcnt), 256'd1);
    chk("aes128_rnd_rk10", 256'(got[10]), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    build(6, {k192, 64'h0});
    run(1, 0, -1, nhs, dcyc, dcnt);
    chk("aes192_handshakes", 256'(nhs), 256'd13);
    chk("aes192_done_cycle", 256'(dcyc), 256'd53);
    chk("aes192_w6", 256'(got[1][63:32]), 256'(32'hfe0c91f7));
    build(8, k256);
    run(2, 0, -1, nhs, dcyc, dcnt);
    chk("aes256_handshakes", 256'(nhs), 256'd15);
    chk("aes256_done_cycle", 256'(dcyc), 256'd61);
    chk("aes256_rk0", 256'(got[0]), 256'(k256[255:128]));
    chk("aes256_rk1", 256'(got[1]), 256'(k256[127:0]));
    chk("aes256_rk2_w0", 256'(got[2][127:96]), 256'(32'h9ba35411));
    build(4, {k128, 128'h0});
    run(0, 0, 4, nhs, dcyc, dcnt);
    chk("abort_no_done", 256'(dcnt), 256'd0);
    #2 rst_n = 1'b0;
    #1 chk("abort_reset_zero", 256'({bz[0], rv[0], dn[0], ri[0], ro[0]}), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 0, -1, nhs, dcyc, dcnt);
    chk("restart_handshakes", 256'(nhs), 256'd11);
    chk("restart_done_cycle", 256'(dcyc), 256'd45);
    chk("restart_done_once", 256'(dcnt), 256'd1);
    k192 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    build(6, {k192, 64'h0});
    run(1, 1, -1, nhs, dcyc, dcnt);
    chk("aes192_rnd_handshakes", 256'(nhs), 256'd13);
    chk("aes192_rnd_done_once", 256'(dcnt), 256'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
